// File: rtl/seq_loop_pkg.sv
// rtl/seq_loop_pkg.sv - shared types and constants for the sequential loop monitor
// Contents:
//   loop_st_e    : monitor FSM states (IDLE, IN_LOOP, DONE)
//   CNT_ALL_ONES : all-ones source, sliced to the counter width for saturation
package seq_loop_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IN_LOOP = 2'd1,
        DONE    = 2'd2
    } loop_st_e;

    // Counters may be up to 64 bits wide; the top slices this to its own width.
    localparam logic [63:0] CNT_ALL_ONES = '1;

endpackage

// File: rtl/seq_loop_state_match.sv
// rtl/seq_loop_state_match.sv - match one FSM state against a packed, masked state list
// Ports:
//   state : FSM_WIDTH        state value to look up
//   list  : N*FSM_WIDTH      packed entries, entry i at [i*FSM_WIDTH +: FSM_WIDTH]
//   valid : N                per-entry enable; an all-zero mask never matches
//   hit   : 1                state equals at least one enabled entry
module seq_loop_state_match #(
    parameter int FSM_WIDTH = 2,
    parameter int N         = 1
) (
    input  logic [FSM_WIDTH-1:0]   state,
    input  logic [N*FSM_WIDTH-1:0] list,
    input  logic [N-1:0]           valid,
    output logic                   hit
);

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (valid[i] && (list[i*FSM_WIDTH +: FSM_WIDTH] == state)) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_loop_monitor.sv
// rtl/seq_loop_monitor.sv - cosim checker for one HLS sequential loop
// Watches cur_state against pre/iter-end/quit/post state lists and reports loop
// entry/exit, iteration and trip counts, hangs and unterminated runs.
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   cur_state             : observed FSM state
//   *_states / *_valid    : packed state lists with per-entry valid masks
//   loop_quit_state       : state entered on a quit edge
//   iter_start_state      : first state of each iteration
//   one_state_loop        : loop body is the single state iter_start_state
//   one_state_block       : holding a state is legal; watchdog disabled
//   finish                : simulation end
//   in_loop, loop_enter, loop_exit           : loop status and 1-cycle pulses
//   iter_count, trip_count, loop_count       : saturating counters
//   cnt_overflow, stall_detected, err_unterminated, done : sticky flags
module seq_loop_monitor
    import seq_loop_pkg::*;
#(
    parameter int FSM_WIDTH  = 2,
    parameter int N_PRE      = 1,
    parameter int N_POST     = 2,
    parameter int N_QUIT     = 3,
    parameter int N_ITER_END = 1,
    parameter int CNT_WIDTH  = 32,
    parameter int HANG_LIMIT = 1024
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [FSM_WIDTH-1:0]              cur_state,
    input  logic [N_PRE*FSM_WIDTH-1:0]        pre_states,
    input  logic [N_PRE-1:0]                  pre_valid,
    input  logic [N_POST*FSM_WIDTH-1:0]       post_states,
    input  logic [N_POST-1:0]                 post_valid,
    input  logic [N_QUIT*FSM_WIDTH-1:0]       quit_states,
    input  logic [N_QUIT-1:0]                 quit_valid,
    input  logic [N_ITER_END*FSM_WIDTH-1:0]   iter_end_states,
    input  logic [N_ITER_END-1:0]             iter_end_valid,
    input  logic [FSM_WIDTH-1:0]              loop_quit_state,
    input  logic [FSM_WIDTH-1:0]              iter_start_state,
    input  logic                              one_state_loop,
    input  logic                              one_state_block,
    input  logic                              finish,
    output logic                              in_loop,
    output logic                              loop_enter,
    output logic                              loop_exit,
    output logic [CNT_WIDTH-1:0]              iter_count,
    output logic [CNT_WIDTH-1:0]              trip_count,
    output logic [CNT_WIDTH-1:0]              loop_count,
    output logic                              cnt_overflow,
    output logic                              stall_detected,
    output logic                              err_unterminated,
    output logic                              done
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_ALL_ONES[CNT_WIDTH-1:0];
    localparam int                   WD_W    = $clog2(HANG_LIMIT + 1);
    localparam logic [WD_W-1:0]      WD_MAX  = WD_W'(HANG_LIMIT);

    loop_st_e               state_q, state_d;
    logic [FSM_WIDTH-1:0]   prev_state;
    logic [WD_W-1:0]        wd_cnt, wd_next;

    logic pre_hit, iter_end_hit, quit_hit, post_hit, start_hit;
    logic enter_edge, exit_edge, iter_edge, wd_hold;
    logic do_enter, do_exit, do_iter, do_finish, wd_count;

    // Edge sources are looked up on prev_state; post membership and the
    // iteration start are looked up on cur_state.
    seq_loop_state_match #(.FSM_WIDTH(FSM_WIDTH), .N(N_PRE)) u_pre_match (
        .state(prev_state), .list(pre_states), .valid(pre_valid), .hit(pre_hit)
    );
    seq_loop_state_match #(.FSM_WIDTH(FSM_WIDTH), .N(N_ITER_END)) u_iter_end_match (
        .state(prev_state), .list(iter_end_states), .valid(iter_end_valid), .hit(iter_end_hit)
    );
    seq_loop_state_match #(.FSM_WIDTH(FSM_WIDTH), .N(N_QUIT)) u_quit_match (
        .state(prev_state), .list(quit_states), .valid(quit_valid), .hit(quit_hit)
    );
    seq_loop_state_match #(.FSM_WIDTH(FSM_WIDTH), .N(N_POST)) u_post_match (
        .state(cur_state), .list(post_states), .valid(post_valid), .hit(post_hit)
    );
    seq_loop_state_match #(.FSM_WIDTH(FSM_WIDTH), .N(1)) u_start_match (
        .state(cur_state), .list(iter_start_state), .valid(1'b1), .hit(start_hit)
    );

    assign enter_edge = pre_hit && start_hit;
    assign exit_edge  = (quit_hit && (cur_state == loop_quit_state)) || post_hit;
    // A single-state body completes one iteration every cycle it dwells.
    assign iter_edge  = (iter_end_hit && start_hit) ||
                        (one_state_loop && start_hit && (prev_state == cur_state));
    assign wd_hold    = (cur_state == prev_state) && !one_state_loop && !one_state_block;
    assign wd_next    = (wd_cnt == WD_MAX) ? WD_MAX : wd_cnt + WD_W'(1);

    // finish takes priority over every loop event; exit takes priority over
    // iteration, with the final iteration folded into trip_count.
    always_comb begin
        state_d   = state_q;
        do_enter  = 1'b0;
        do_exit   = 1'b0;
        do_iter   = 1'b0;
        do_finish = 1'b0;
        wd_count  = 1'b0;
        case (state_q)
            IDLE: begin
                if (finish) begin
                    state_d   = DONE;
                    do_finish = 1'b1;
                end else if (enter_edge) begin
                    state_d  = IN_LOOP;
                    do_enter = 1'b1;
                end
            end
            IN_LOOP: begin
                if (finish) begin
                    state_d   = DONE;
                    do_finish = 1'b1;
                end else begin
                    wd_count = wd_hold;
                    if (exit_edge) begin
                        state_d = IDLE;
                        do_exit = 1'b1;
                    end else begin
                        do_iter = iter_edge;
                    end
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= IDLE;
            prev_state       <= '0;
            wd_cnt           <= '0;
            in_loop          <= 1'b0;
            loop_enter       <= 1'b0;
            loop_exit        <= 1'b0;
            iter_count       <= '0;
            trip_count       <= '0;
            loop_count       <= '0;
            cnt_overflow     <= 1'b0;
            stall_detected   <= 1'b0;
            err_unterminated <= 1'b0;
            done             <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_state <= cur_state;
            in_loop    <= (state_d == IN_LOOP);
            loop_enter <= do_enter;
            loop_exit  <= do_exit;

            if (do_finish) begin
                done <= 1'b1;
                if (state_q == IN_LOOP) begin
                    err_unterminated <= 1'b1;
                end
            end

            if (do_enter) begin
                iter_count <= '0;
            end else if (do_iter && (iter_count != CNT_MAX)) begin
                iter_count <= iter_count + CNT_WIDTH'(1);
            end

            if (do_exit) begin
                trip_count <= (iter_count == CNT_MAX) ? CNT_MAX : iter_count + CNT_WIDTH'(1);
                if (loop_count != CNT_MAX) begin
                    loop_count <= loop_count + CNT_WIDTH'(1);
                end
            end

            if ((do_iter && (iter_count == CNT_MAX)) ||
                (do_exit && ((iter_count == CNT_MAX) || (loop_count == CNT_MAX)))) begin
                cnt_overflow <= 1'b1;
            end

            if (wd_count) begin
                wd_cnt <= wd_next;
                if (wd_next == WD_MAX) begin
                    stall_detected <= 1'b1;
                end
            end else begin
                wd_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_seq_loop_monitor.sv
// tb/tb_seq_loop_monitor.sv - self-checking bench for seq_loop_monitor (wide and 2-bit counter instances)
module tb_seq_loop_monitor;

    localparam int HANG = 8;

    logic       clock = 1'b0;
    logic       reset, finish, one_state_loop, one_state_block;
    logic [1:0] cur_state, loop_quit_state, iter_start_state;
    logic [1:0] pre_states, iter_end_states;
    logic [3:0] post_states;
    logic [5:0] quit_states;
    logic [0:0] pre_valid, iter_end_valid;
    logic [1:0] post_valid;
    logic [2:0] quit_valid;

    logic       a_in_loop, a_enter, a_exit, a_ovf, a_stall, a_err, a_done;
    logic [7:0] a_iter, a_trip, a_loop;
    logic       b_in_loop, b_enter, b_exit, b_ovf, b_stall, b_err, b_done;
    logic [1:0] b_iter, b_trip, b_loop;

    int n_vec = 0;
    int n_err = 0;
    int enter_seen = 0;
    int exit_seen = 0;
    bit chk_en = 1'b0;

    // model
    bit    m_in_loop, m_done, m_enter, m_exit, m_stall, m_err, m_ovf_a, m_ovf_b;
    longint m_iter, m_trip, m_loops, m_run;
    logic [1:0] m_prev;

    always #5 clock = ~clock;

    seq_loop_monitor #(.FSM_WIDTH(2), .N_PRE(1), .N_POST(2), .N_QUIT(3), .N_ITER_END(1),
                       .CNT_WIDTH(8), .HANG_LIMIT(HANG)) dut_a (
        .clock(clock), .reset(reset), .cur_state(cur_state),
        .pre_states(pre_states), .pre_valid(pre_valid),
        .post_states(post_states), .post_valid(post_valid),
        .quit_states(quit_states), .quit_valid(quit_valid),
        .iter_end_states(iter_end_states), .iter_end_valid(iter_end_valid),
        .loop_quit_state(loop_quit_state), .iter_start_state(iter_start_state),
        .one_state_loop(one_state_loop), .one_state_block(one_state_block), .finish(finish),
        .in_loop(a_in_loop), .loop_enter(a_enter), .loop_exit(a_exit),
        .iter_count(a_iter), .trip_count(a_trip), .loop_count(a_loop),
        .cnt_overflow(a_ovf), .stall_detected(a_stall), .err_unterminated(a_err), .done(a_done)
    );

    seq_loop_monitor #(.FSM_WIDTH(2), .N_PRE(1), .N_POST(2), .N_QUIT(3), .N_ITER_END(1),
                       .CNT_WIDTH(2), .HANG_LIMIT(HANG)) dut_b (
        .clock(clock), .reset(reset), .cur_state(cur_state),
        .pre_states(pre_states), .pre_valid(pre_valid),
        .post_states(post_states), .post_valid(post_valid),
        .quit_states(quit_states), .quit_valid(quit_valid),
        .iter_end_states(iter_end_states), .iter_end_valid(iter_end_valid),
        .loop_quit_state(loop_quit_state), .iter_start_state(iter_start_state),
        .one_state_loop(one_state_loop), .one_state_block(one_state_block), .finish(finish),
        .in_loop(b_in_loop), .loop_enter(b_enter), .loop_exit(b_exit),
        .iter_count(b_iter), .trip_count(b_trip), .loop_count(b_loop),
        .cnt_overflow(b_ovf), .stall_detected(b_stall), .err_unterminated(b_err), .done(b_done)
    );

    function automatic bit in_list(input logic [31:0] lst, input logic [7:0] vld,
                                   input int n, input logic [1:0] s);
        for (int i = 0; i < n; i++) begin
            if (vld[i] && (lst[i*2 +: 2] == s)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic longint sat(input longint v, input longint m);
        return (v > m) ? m : v;
    endfunction

    task automatic cmp(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Loop semantics applied to the inputs of the current cycle.
    task automatic model_update();
        bit quit_e, post_e, iter_e;
        m_enter = 1'b0;
        m_exit  = 1'b0;
        if (reset) begin
            m_in_loop = 0; m_done = 0; m_stall = 0; m_err = 0; m_ovf_a = 0; m_ovf_b = 0;
            m_iter = 0; m_trip = 0; m_loops = 0; m_run = 0;
            m_prev = 2'd0;
            return;
        end
        if (m_done) begin
            // terminal until reset
        end else if (finish) begin
            m_done = 1'b1;
            if (m_in_loop) m_err = 1'b1;
            m_in_loop = 1'b0;
            m_run = 0;
        end else if (!m_in_loop) begin
            m_run = 0;
            if (in_list(32'(pre_states), 8'(pre_valid), 1, m_prev) && cur_state == iter_start_state) begin
                m_in_loop = 1'b1;
                m_enter = 1'b1;
                m_iter = 0;
            end
        end else begin
            if (cur_state == m_prev && !one_state_loop && !one_state_block) m_run++;
            else m_run = 0;
            if (m_run >= HANG) m_stall = 1'b1;
            quit_e = in_list(32'(quit_states), 8'(quit_valid), 3, m_prev) && cur_state == loop_quit_state;
            post_e = in_list(32'(post_states), 8'(post_valid), 2, cur_state);
            iter_e = (in_list(32'(iter_end_states), 8'(iter_end_valid), 1, m_prev) && cur_state == iter_start_state)
                  || (one_state_loop && m_prev == iter_start_state && cur_state == iter_start_state);
            if (quit_e || post_e) begin
                m_exit = 1'b1;
                m_trip = m_iter + 1;
                m_loops++;
                m_in_loop = 1'b0;
            end else if (iter_e) begin
                m_iter++;
            end
        end
        if (m_iter > 255 || m_trip > 255 || m_loops > 255) m_ovf_a = 1'b1;
        if (m_iter > 3 || m_trip > 3 || m_loops > 3) m_ovf_b = 1'b1;
        m_prev = cur_state;
    endtask

    always @(posedge clock) begin
        #1;
        if (chk_en) begin
            enter_seen += int'(a_enter);
            exit_seen  += int'(a_exit);
            cmp("a_in_loop", a_in_loop, m_in_loop);
            cmp("a_loop_enter", a_enter, m_enter);
            cmp("a_loop_exit", a_exit, m_exit);
            cmp("a_iter_count", a_iter, sat(m_iter, 255));
            cmp("a_trip_count", a_trip, sat(m_trip, 255));
            cmp("a_loop_count", a_loop, sat(m_loops, 255));
            cmp("a_cnt_overflow", a_ovf, m_ovf_a);
            cmp("a_stall", a_stall, m_stall);
            cmp("a_err_unterminated", a_err, m_err);
            cmp("a_done", a_done, m_done);
            cmp("b_in_loop", b_in_loop, m_in_loop);
            cmp("b_loop_exit", b_exit, m_exit);
            cmp("b_iter_count", b_iter, sat(m_iter, 3));
            cmp("b_trip_count", b_trip, sat(m_trip, 3));
            cmp("b_loop_count", b_loop, sat(m_loops, 3));
            cmp("b_cnt_overflow", b_ovf, m_ovf_b);
            cmp("b_stall", b_stall, m_stall);
        end
    end

    // Called at a falling edge: apply inputs, advance the model, wait one cycle.
    task automatic step(input logic [1:0] s);
        cur_state = s;
        model_update();
        @(negedge clock);
    endtask

    task automatic play(input string seq);
        for (int i = 0; i < seq.len(); i++) begin
            step(2'(seq[i] - 8'h30));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2'd0);
        reset = 1'b0;
        enter_seen = 0;
        exit_seen = 0;
    endtask

    task automatic cfg_default();
        pre_states = 2'd1;       pre_valid = 1'b1;
        post_states = 4'b0000;   post_valid = 2'b01;
        quit_states = 6'd0;      quit_valid = 3'b000;
        iter_end_states = 2'd3;  iter_end_valid = 1'b1;
        loop_quit_state = 2'd1;  iter_start_state = 2'd2;
        one_state_loop = 1'b0;   one_state_block = 1'b0;
        finish = 1'b0;
    endtask

    initial begin
        cfg_default();
        reset = 1'b0;
        cur_state = 2'd0;
        @(negedge clock);
        chk_en = 1'b1;

        // basic loop via iter_end and post exit
        do_reset();
        cmp("reset_iter", a_iter, 0);
        cmp("reset_done", a_done, 0);
        play("12323230");
        cmp("t1_enter_pulses", enter_seen, 1);
        cmp("t1_iter", a_iter, 2);
        cmp("t1_trip", a_trip, 3);
        cmp("t1_loops", a_loop, 1);

        // one-state loop
        do_reset();
        one_state_loop = 1'b1;
        play("122220");
        cmp("t2_trip_a", a_trip, 4);
        cmp("t2_trip_b", b_trip, 3);
        cmp("t2_ovf_b", b_ovf, 1);
        cmp("t2_ovf_a", a_ovf, 0);
        one_state_loop = 1'b0;

        // quit edge, masked pre list
        do_reset();
        quit_states = 6'b000011; quit_valid = 3'b001;
        post_valid = 2'b00; pre_valid = 1'b0;
        play("1231");
        cmp("t3_no_entry", enter_seen, 0);
        pre_valid = 1'b1;
        play("1231");
        cmp("t3_entry", enter_seen, 1);
        cmp("t3_exit", exit_seen, 1);
        cmp("t3_trip", a_trip, 1);
        cfg_default();

        // watchdog
        do_reset();
        play("1233333333");
        cmp("t4_no_stall_yet", a_stall, 0);
        play("3");
        cmp("t4_stall", a_stall, 1);
        play("0");
        cmp("t4_stall_sticky", a_stall, 1);
        do_reset();
        one_state_block = 1'b1;
        play("12333333333330");
        cmp("t4_block_no_stall", a_stall, 0);
        one_state_block = 1'b0;

        // finish mid-loop, then reset
        do_reset();
        play("123");
        finish = 1'b1;
        step(2'd3);
        finish = 1'b0;
        play("30");
        cmp("t5_done", a_done, 1);
        cmp("t5_err", a_err, 1);
        cmp("t5_no_exit", exit_seen, 0);
        cmp("t5_in_loop", a_in_loop, 0);
        do_reset();
        cmp("t5_reset_done", a_done, 0);
        cmp("t5_reset_err", a_err, 0);

        // 2-bit counter saturation
        do_reset();
        play("123232323232");
        cmp("t6_iter_a", a_iter, 5);
        cmp("t6_iter_b", b_iter, 3);
        cmp("t6_ovf_b", b_ovf, 1);
        cmp("t6_ovf_a", a_ovf, 0);
        play("0");
        cmp("t6_trip_a", a_trip, 6);

        // exit and iteration edge together
        do_reset();
        post_states = 4'b1000; post_valid = 2'b11;
        play("1232");
        cmp("t7_trip", a_trip, 1);
        cmp("t7_iter_held", a_iter, 0);
        cmp("t7_loops", a_loop, 1);
        cfg_default();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
